// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths and queue entry type
// for the instruction fetch queue.
package ifq_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
    logic               filled;
    logic               misalign;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_slot_ram.sv
// ifq_slot_ram: circular slot store with head/tail
// pointers and an oldest-pending fill pointer.
module ifq_slot_ram
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  ifq_entry_t                 push_e,
  input  logic                       fill,
  input  logic [INSTR_W-1:0]         fill_word,
  input  logic                       pop,
  output ifq_entry_t                 head_e,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found;

  // oldest reserved slot still waiting for its word
  always_comb begin
    fill_idx = head_q;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (CW'(i) < cnt_q) &&
          !mem_q[head_q + PW'(i)].filled) begin
        fill_idx = head_q + PW'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (fill) begin
        mem_d[fill_idx].word   = fill_word;
        mem_d[fill_idx].filled = 1'b1;
      end
      if (push) begin
        mem_d[tail_q] = push_e;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_e = mem_q[head_q];
  assign count  = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: PC-to-decode fetch queue with in-order imem.
// Define IFQ_ALIGN_CHECK_EN to add the ins_misalign output.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [ADDR_W-1:0]  ins_pc,
  output logic [INSTR_W-1:0] ins_word,
  input  logic               flush
`ifdef IFQ_ALIGN_CHECK_EN
  ,
  output logic               ins_misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  ifq_entry_t    head_e, push_e;
  logic          misal, accept, req;
  logic          rsp_live, fill, ins_fire;

  always_comb begin
    misal = 1'b0;
`ifdef IFQ_ALIGN_CHECK_EN
    misal = pc_in[1:0] != 2'b00;
`endif
    // dropped requests are still in flight at the memory
    pc_ready = rst && !flush &&
               (count < CW'(DEPTH)) &&
               ((outst_q + drop_q) < CW'(MAX_OUTST));
    accept   = pc_valid && pc_ready;
    req      = accept && !misal;
    rsp_live = imem_rvalid &&
               ((drop_q != '0) || (outst_q != '0));
    fill     = imem_rvalid && !flush &&
               (drop_q == '0) && (outst_q != '0);
    if (flush) begin
      outst_d = '0;
      drop_d  = drop_q + outst_q - CW'(rsp_live);
    end else begin
      outst_d = outst_q + CW'(req) - CW'(fill);
      drop_d  = drop_q -
                CW'(imem_rvalid && (drop_q != '0));
    end
    push_e = '{pc:       pc_in,
               word:     INSTR_W'(0),
               filled:   misal,
               misalign: misal};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  ifq_slot_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (accept),
    .push_e   (push_e),
    .fill     (fill),
    .fill_word(imem_rdata),
    .pop      (ins_fire),
    .head_e   (head_e),
    .count    (count)
  );

  assign imem_req  = req;
  assign imem_addr = pc_in;
  assign ins_valid = (count != '0) && head_e.filled;
  assign ins_fire  = ins_valid && ins_ready;
  assign ins_pc    = ins_valid ? head_e.pc : '0;
  assign ins_word  = (ins_valid && !head_e.misalign) ?
                     head_e.word : '0;
`ifdef IFQ_ALIGN_CHECK_EN
  assign ins_misalign = ins_valid && head_e.misalign;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench with an in-order
// variable-latency instruction memory model.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_pc;
  logic [31:0] ins_word;
  logic        flush;
`ifdef IFQ_ALIGN_CHECK_EN
  logic        ins_misalign;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        mis;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  sb[$];
  mreq_t mq[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    lat     = 1;
  int    max_if  = 0;
  int    req_cnt = 0;
  bit    track   = 0;
  bit    spur    = 0;

  ifetch_queue #(
    .DEPTH    (4),
    .MAX_OUTST(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_pc     (ins_pc),
    .ins_word   (ins_word),
    .flush      (flush)
`ifdef IFQ_ALIGN_CHECK_EN
    ,
    .ins_misalign(ins_misalign)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still going, required finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: word returned is ~addr, in request order
  initial begin
    mreq_t m;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        mq.push_back('{imem_addr, cyc + lat});
        req_cnt++;
      end
      if (track && (mq.size() + int'(imem_rvalid)) > max_if)
        max_if = mq.size() + int'(imem_rvalid);
      @(posedge clk);
      cyc++;
      #1;
      if (spur) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        m = mq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = ~m.addr;
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && !flush && ins_valid && ins_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ins: got pc %h expected none",
                   ins_pc);
        end else begin
          e = sb.pop_front();
          chk("ins_pc", ins_pc, e.pc);
          chk("ins_word", ins_word, e.word);
`ifdef IFQ_ALIGN_CHECK_EN
          chk("ins_misalign", 32'(ins_misalign), 32'(e.mis));
`endif
          if (e.lat > 0)
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic send(input logic [31:0] pc,
                      input logic [31:0] word,
                      input logic        mis,
                      input int          lc);
    bit acc = 0;
    pc_valid = 1'b1;
    pc_in    = pc;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (pc_ready) begin
        acc = 1;
        sb.push_back('{pc, word, mis, cyc, lc});
      end
      @(posedge clk);
      #1;
    end
    pc_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pc %h got no accept, required accept",
               pc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mq.size() != 0 || imem_rvalid) &&
           n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] w2 [4];
  int          n_acc;
  int          r0;

  initial begin
    w2 = '{32'hFFFF_FFDF, 32'hFFFF_FFDB,
           32'hFFFF_FFD7, 32'hFFFF_FFD3};
    rst       = 1'b0;
    pc_valid  = 1'b1;
    pc_in     = 32'h10;
    ins_ready = 1'b1;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_ready", 32'(pc_ready), 32'd0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    chk("rst_ins_word", ins_word, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    pc_valid = 1'b0;

    // stray response with nothing outstanding
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_ins_valid", 32'(ins_valid), 32'd0);
    chk("spur_count", 32'(dut.u_ram.cnt_q), 32'd0);
    @(posedge clk);
    #1;

    lat = 1;
    send(32'h0, 32'hFFFF_FFFF, 1'b0, 2);
    send(32'h4, 32'hFFFF_FFFB, 1'b0, 2);
    send(32'h8, 32'hFFFF_FFF7, 1'b0, 2);
    send(32'hC, 32'hFFFF_FFF3, 1'b0, 2);
    drain();

    lat       = 3;
    ins_ready = 1'b0;
    n_acc     = 0;
    pc_valid  = 1'b1;
    pc_in     = 32'h20;
    repeat (25) begin
      @(negedge clk);
      if (pc_ready) begin
        if (n_acc < 4)
          sb.push_back('{pc_in, w2[n_acc], 1'b0, cyc, 0});
        else
          sb.push_back('{pc_in, 32'h0, 1'b0, cyc, 0});
        n_acc++;
      end
      @(posedge clk);
      #1;
      pc_in = 32'h20 + 32'(4 * n_acc);
    end
    @(negedge clk);
    chk("full_accepts", 32'(n_acc), 32'd4);
    chk("full_pc_ready", 32'(pc_ready), 32'd0);
    @(posedge clk);
    #1;
    pc_valid  = 1'b0;
    ins_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_pc_ready", 32'(pc_ready), 32'd0);
    @(negedge clk);
    chk("after_pop_pc_ready", 32'(pc_ready), 32'd1);
    @(posedge clk);
    #1;
    drain();

    lat    = 5;
    max_if = 0;
    track  = 1'b1;
    send(32'h60, 32'hFFFF_FF9F, 1'b0, 0);
    send(32'h64, 32'hFFFF_FF9B, 1'b0, 0);
    send(32'h68, 32'hFFFF_FF97, 1'b0, 0);
    send(32'h6C, 32'hFFFF_FF93, 1'b0, 0);
    send(32'h70, 32'hFFFF_FF8F, 1'b0, 0);
    drain();
    track = 1'b0;
    chk("max_outstanding", 32'(max_if), 32'd2);

    lat = 4;
    send(32'h40, 32'hFFFF_FFBF, 1'b0, 0);
    send(32'h44, 32'hFFFF_FFBB, 1'b0, 0);
    flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_pc_ready", 32'(pc_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ins_valid", 32'(ins_valid), 32'd0);
    chk("flush_drop_cnt", 32'(dut.drop_q), 32'd2);
    @(posedge clk);
    #1;
    send(32'h100, 32'hFFFF_FEFF, 1'b0, 0);
    drain();

    lat       = 1;
    ins_ready = 1'b0;
    send(32'h80, 32'hFFFF_FF7F, 1'b0, 0);
    send(32'h84, 32'hFFFF_FF7B, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    send(32'h88, 32'hFFFF_FF77, 1'b0, 0);
    ins_ready = 1'b1;
    pc_valid  = 1'b1;
    pc_in     = 32'h8C;
    @(negedge clk);
    chk("fill_pop_accept",
        {29'd0, imem_rvalid, ins_valid && ins_ready, pc_ready},
        32'd7);
    if (pc_ready)
      sb.push_back('{32'h8C, 32'hFFFF_FF73, 1'b0, cyc, 0});
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    @(negedge clk);
    chk("occupancy_held", 32'(dut.u_ram.cnt_q), 32'd3);
    @(posedge clk);
    #1;
    drain();

`ifdef IFQ_ALIGN_CHECK_EN
    r0 = req_cnt;
    send(32'h6, 32'h0, 1'b1, 0);
    drain();
    chk("misalign_no_req", 32'(req_cnt - r0), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
